// File: rtl/mem_dispatch_pkg.sv
// Shared types and width helpers for the memory request dispatcher.
// Used by mem_req_dispatch and mem_batch_tracker.
package mem_dispatch_pkg;

    // Outstanding counter must represent 0..2^sel_bits inclusive.
    function automatic int unsigned batch_cnt_w(input int unsigned sel_bits);
        return sel_bits + 1;
    endfunction

    // Downstream tag carries the upstream tag plus the batch id in the LSBs.
    function automatic int unsigned out_tag_w(input int unsigned tag_w,
                                              input int unsigned sel_bits);
        return tag_w + sel_bits;
    endfunction

    // Per-lane request at the default widths (32b addr/data, 8+2b tag).
    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [9:0]  tag;
    } mem_lane_req_t;

endpackage

// File: rtl/mem_batch_tracker.sv
// Batch id generator and outstanding-batch counter.
// Raises stall once every batch id is in flight, so ids never alias.
module mem_batch_tracker
    import mem_dispatch_pkg::*;
#(
    parameter int unsigned TAG_SEL_BITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    batch_start,
    input  logic                    rsp_batch_done,
    output logic [TAG_SEL_BITS-1:0] batch_id,
    output logic                    stall
);

    localparam int unsigned CW = batch_cnt_w(TAG_SEL_BITS);
    localparam logic [CW-1:0] FULL = {1'b1, {TAG_SEL_BITS{1'b0}}};

    logic [CW-1:0] outstanding;

    assign stall = (outstanding == FULL);

    // Advance batch id on each issued batch; net the in-flight count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            batch_id    <= '0;
            outstanding <= '0;
        end else begin
            if (batch_start)
                batch_id <= batch_id + 1'b1;
            if (batch_start && !rsp_batch_done)
                outstanding <= outstanding + 1'b1;
            else if (!batch_start && rsp_batch_done && outstanding != '0)
                outstanding <= outstanding - 1'b1;
        end
    end

    // A retirement with nothing in flight means the downstream is confused.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (reset)
        !(rsp_batch_done && outstanding == '0)
    ) else $error("rsp_batch_done with no outstanding batch");

endmodule

// File: rtl/mem_req_dispatch.sv
// Splits a multi-lane request bundle into per-lane memory requests,
// tagging each with a batch id. Optional perf counters: MEM_REQ_DISPATCH_PERF_EN.
module mem_req_dispatch
    import mem_dispatch_pkg::*;
#(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned TAG_SEL_BITS = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       req_valid_in,
    input  logic                                       req_rw_in,
    input  logic [NUM_REQS-1:0]                        req_mask_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]             req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]             req_data_in,
    input  logic [TAG_WIDTH-1:0]                       req_tag_in,
    output logic                                       req_ready_in,
    output logic [NUM_REQS-1:0]                        req_valid_out,
    output logic [NUM_REQS-1:0]                        req_rw_out,
    output logic [NUM_REQS*ADDR_WIDTH-1:0]             req_addr_out,
    output logic [NUM_REQS*DATA_WIDTH-1:0]             req_data_out,
    output logic [NUM_REQS*(TAG_WIDTH+TAG_SEL_BITS)-1:0] req_tag_out,
    input  logic [NUM_REQS-1:0]                        req_ready_out,
    input  logic                                       rsp_batch_done
`ifdef MEM_REQ_DISPATCH_PERF_EN
    ,
    output logic [31:0]                                perf_stall_cycles,
    output logic [31:0]                                perf_partial_cycles
`endif
);

    localparam int unsigned OTW = out_tag_w(TAG_WIDTH, TAG_SEL_BITS);

    logic [NUM_REQS-1:0]     sent_mask;
    logic [NUM_REQS-1:0]     lane_pend;
    logic [NUM_REQS-1:0]     fire;
    logic [TAG_SEL_BITS-1:0] batch_id;
    logic                    stall;
    logic                    go;
    logic                    done;
    logic                    batch_start;

    assign go        = ~reset & req_valid_in & ~stall;
    assign lane_pend = req_mask_in & ~sent_mask;

    assign req_valid_out = go ? lane_pend : '0;
    assign fire          = req_valid_out & req_ready_out;
    assign done          = go & ((lane_pend & ~fire) == '0);
    assign req_ready_in  = done;
    assign batch_start   = done & (|req_mask_in);

    assign req_rw_out   = {NUM_REQS{req_rw_in}};
    assign req_addr_out = req_addr_in;
    assign req_data_out = req_data_in;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_tag
        assign req_tag_out[i*OTW +: OTW] = {req_tag_in, batch_id};
    end

    mem_batch_tracker #(
        .TAG_SEL_BITS (TAG_SEL_BITS)
    ) u_tracker (
        .clk            (clk),
        .reset          (reset),
        .batch_start    (batch_start),
        .rsp_batch_done (rsp_batch_done),
        .batch_id       (batch_id),
        .stall          (stall)
    );

    // Remember issued lanes until the whole bundle is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sent_mask <= '0;
        else if (done)
            sent_mask <= '0;
        else
            sent_mask <= sent_mask | fire;
    end

`ifdef MEM_REQ_DISPATCH_PERF_EN
    // Count stalled and partially-issued bundle cycles; wrap on overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles   <= '0;
            perf_partial_cycles <= '0;
        end else begin
            if (req_valid_in && stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (req_valid_in && !stall && !done)
                perf_partial_cycles <= perf_partial_cycles + 32'd1;
        end
    end
`endif

    // A pending bundle must be held steady until it is accepted.
    a_hold_stable: assert property (
        @(posedge clk) disable iff (reset)
        $past(req_valid_in && !req_ready_in && !reset) |->
            (req_valid_in && $stable(req_rw_in) && $stable(req_mask_in) &&
             $stable(req_addr_in) && $stable(req_data_in) &&
             $stable(req_tag_in))
    ) else $error("request bundle changed while pending");

endmodule

// File: tb/tb_mem_req_dispatch.sv
// Directed testbench for mem_req_dispatch (default parameters).
// Expected values are hand-computed per vector.
module tb_mem_req_dispatch;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int SB  = 2;
    localparam int OTW = TW + SB;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid_in;
    logic              req_rw_in;
    logic [N-1:0]      req_mask_in;
    logic [N*AW-1:0]   req_addr_in;
    logic [N*DW-1:0]   req_data_in;
    logic [TW-1:0]     req_tag_in;
    logic              req_ready_in;
    logic [N-1:0]      req_valid_out;
    logic [N-1:0]      req_rw_out;
    logic [N*AW-1:0]   req_addr_out;
    logic [N*DW-1:0]   req_data_out;
    logic [N*OTW-1:0]  req_tag_out;
    logic [N-1:0]      req_ready_out;
    logic              rsp_batch_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_req_dispatch dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_in   (req_valid_in),
        .req_rw_in      (req_rw_in),
        .req_mask_in    (req_mask_in),
        .req_addr_in    (req_addr_in),
        .req_data_in    (req_data_in),
        .req_tag_in     (req_tag_in),
        .req_ready_in   (req_ready_in),
        .req_valid_out  (req_valid_out),
        .req_rw_out     (req_rw_out),
        .req_addr_out   (req_addr_out),
        .req_data_out   (req_data_out),
        .req_tag_out    (req_tag_out),
        .req_ready_out  (req_ready_out),
        .rsp_batch_done (rsp_batch_done)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OTW-1:0] tag_of(input int lane);
        return req_tag_out[lane*OTW +: OTW];
    endfunction

    initial begin
        reset          = 1'b1;
        req_valid_in   = 1'b1;
        req_rw_in      = 1'b1;
        req_mask_in    = 4'b1111;
        req_tag_in     = 8'h5A;
        req_ready_out  = 4'b1111;
        rsp_batch_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr_in[i*AW +: AW] = 32'h100 + i;
            req_data_in[i*DW +: DW] = 32'hD0 + i;
        end
        #1;
        chk("rst_valid", req_valid_out, 4'b0000);
        chk("rst_ready", req_ready_in, 1'b0);
        step();
        step();
        reset = 1'b0;
        req_valid_in = 1'b0;
        step();

        // Single-cycle issue, mask 1011, batch 0
        req_valid_in = 1'b1;
        req_mask_in  = 4'b1011;
        #1;
        chk("t1_valid", req_valid_out, 4'b1011);
        chk("t1_ready", req_ready_in, 1'b1);
        chk("t1_tag0", tag_of(0), {8'h5A, 2'b00});
        chk("t1_addr3", req_addr_out[3*AW +: AW], 32'h103);
        chk("t1_data1", req_data_out[1*DW +: DW], 32'hD1);
        chk("t1_rw", req_rw_out, 4'b1111);
        step();

        // Next bundle takes batch 1
        req_mask_in = 4'b0001;
        req_tag_in  = 8'h11;
        #1;
        chk("t1b_tag0", tag_of(0), {8'h11, 2'b01});
        chk("t1b_ready", req_ready_in, 1'b1);
        step();

        // Split issue over two cycles, batch 2
        req_mask_in   = 4'b1111;
        req_tag_in    = 8'h33;
        req_rw_in     = 1'b0;
        req_ready_out = 4'b0101;
        #1;
        chk("t2c0_valid", req_valid_out, 4'b1111);
        chk("t2c0_ready", req_ready_in, 1'b0);
        chk("t2c0_rw", req_rw_out, 4'b0000);
        step();
        req_ready_out = 4'b1010;
        #1;
        chk("t2c1_valid", req_valid_out, 4'b1010);
        chk("t2c1_ready", req_ready_in, 1'b1);
        chk("t2c1_tag1", tag_of(1), {8'h33, 2'b10});
        step();

        // Empty mask: accepted, no lanes, no batch consumed
        req_ready_out = 4'b1111;
        req_mask_in   = 4'b0000;
        #1;
        chk("t4_valid", req_valid_out, 4'b0000);
        chk("t4_ready", req_ready_in, 1'b1);
        step();
        req_mask_in = 4'b0001;
        req_tag_in  = 8'h44;
        #1;
        chk("t4_tag_keep", tag_of(0), {8'h44, 2'b11});
        chk("t4b_ready", req_ready_in, 1'b1);
        step();

        // Four batches outstanding: stall
        req_mask_in = 4'b1111;
        req_tag_in  = 8'h77;
        #1;
        chk("t3_stall_valid", req_valid_out, 4'b0000);
        chk("t3_stall_ready", req_ready_in, 1'b0);
        step();
        rsp_batch_done = 1'b1;
        #1;
        chk("t3_rsp_cyc_valid", req_valid_out, 4'b0000);
        step();
        // Released: issue with batch 0 while another batch retires
        #1;
        chk("t3_rel_valid", req_valid_out, 4'b1111);
        chk("t3_rel_ready", req_ready_in, 1'b1);
        chk("t3_rel_tag2", tag_of(2), {8'h77, 2'b00});
        step();
        rsp_batch_done = 1'b0;
        req_mask_in = 4'b0001;
        req_tag_in  = 8'h22;
        #1;
        chk("t5_tag_adv", tag_of(0), {8'h22, 2'b01});
        chk("t5_ready", req_ready_in, 1'b1);
        step();
        // Outstanding back at 4: stalled again
        req_mask_in   = 4'b1111;
        req_tag_in    = 8'h99;
        req_ready_out = 4'b0011;
        #1;
        chk("t5_stall", req_valid_out, 4'b0000);
        rsp_batch_done = 1'b1;
        step();
        rsp_batch_done = 1'b0;
        #1;
        chk("t6_c0_valid", req_valid_out, 4'b1111);
        chk("t6_c0_ready", req_ready_in, 1'b0);
        chk("t6_c0_tag", tag_of(0), {8'h99, 2'b10});
        step();
        #1;
        chk("t6_part_valid", req_valid_out, 4'b1100);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", req_valid_out, 4'b0000);
        chk("t6_rst_ready", req_ready_in, 1'b0);
        step();
        reset = 1'b0;
        req_ready_out = 4'b1111;
        #1;
        chk("t6_re_valid", req_valid_out, 4'b1111);
        chk("t6_re_ready", req_ready_in, 1'b1);
        chk("t6_re_tag3", tag_of(3), {8'h99, 2'b00});
        step();
        req_valid_in = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
